segre_mem_stage: RTL and testbench

//  MEM stage of the Segre pipeline; consumes the EX/MEM interface (ALU result, rf write info, memop controls, taken-branch).

---
 rtl/segre_mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_segre_mem_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_stage.sv
// MEM stage: executes loads/stores over a req/ack data-memory port and produces the MEM/WB slot.
// Latency: 1 cycle for non-memory ops, at least 2 cycles for memops (accept, then ack -> WB next edge).
// Backpressure: stall_o holds the EX/MEM slot while a request waits for dmem_ack_i.
// Option: define SEGRE_MEM_MISALIGN_TRAP_EN to flag misaligned HALF/WORD accesses instead of issuing them.
module segre_mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 5
) (
    input  logic                     clk_i,
    input  logic                     rsn_i,
    input  logic                     valid_i,
    input  logic [WORD_SIZE-1:0]     alu_res_i,
    input  logic                     rf_we_i,
    input  logic [REG_SIZE-1:0]      rf_waddr_i,
    input  logic [WORD_SIZE-1:0]     rf_st_data_i,
    input  logic [1:0]               memop_type_i,
    input  logic                     memop_rd_i,
    input  logic                     memop_wr_i,
    input  logic                     memop_sign_ext_i,
    input  logic                     tkbr_i,
    input  logic [WORD_SIZE-1:0]     new_pc_i,
    output logic                     stall_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [WORD_SIZE-1:0]     dmem_addr_o,
    output logic [WORD_SIZE/8-1:0]   dmem_be_o,
    output logic [WORD_SIZE-1:0]     dmem_wdata_o,
    input  logic                     dmem_ack_i,
    input  logic [WORD_SIZE-1:0]     dmem_rdata_i,
    output logic                     wb_valid_o,
    output logic                     rf_we_o,
    output logic [REG_SIZE-1:0]      rf_waddr_o,
    output logic [WORD_SIZE-1:0]     rf_data_o,
    output logic                     tkbr_o,
    output logic [WORD_SIZE-1:0]     new_pc_o,
    output logic                     misaligned_o
);

    localparam int BE_W = WORD_SIZE / 8;

    // memop_type_i encoding: 0 = BYTE, 1 = HALF, 2 = WORD
    localparam logic [1:0] MT_BYTE = 2'd0;
    localparam logic [1:0] MT_HALF = 2'd1;

    typedef enum logic {S_IDLE, S_REQ} state_e;

    state_e                 state;
    logic [1:0]             cap_off;
    logic [1:0]             cap_type;
    logic                   cap_sext;
    logic                   cap_store;
    logic                   cap_we;
    logic [REG_SIZE-1:0]    cap_waddr;

    logic                   in_is_mem;
    logic [1:0]             in_off;
    logic [BE_W-1:0]        in_be;
    logic [WORD_SIZE-1:0]   in_wdata;
    logic [WORD_SIZE-1:0]   ld_shift;
    logic [WORD_SIZE-1:0]   ld_data;

    assign in_is_mem = memop_rd_i | memop_wr_i;
    assign stall_o   = (state == S_REQ) & ~dmem_ack_i;

    // Offset honours only the alignment bits meaningful for the access size.
    always_comb begin
        in_off   = 2'b00;
        in_be    = '1;
        in_wdata = rf_st_data_i;
        case (memop_type_i)
            MT_BYTE: begin
                in_off   = alu_res_i[1:0];
                in_be    = BE_W'(1) << in_off;
                in_wdata = {(WORD_SIZE/8){rf_st_data_i[7:0]}};
            end
            MT_HALF: begin
                in_off   = {alu_res_i[1], 1'b0};
                in_be    = BE_W'(3) << in_off;
                in_wdata = {(WORD_SIZE/16){rf_st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_shift = dmem_rdata_i >> {cap_off, 3'b000};

    always_comb begin
        ld_data = ld_shift;
        case (cap_type)
            MT_BYTE: ld_data = {{(WORD_SIZE-8){cap_sext & ld_shift[7]}}, ld_shift[7:0]};
            MT_HALF: ld_data = {{(WORD_SIZE-16){cap_sext & ld_shift[15]}}, ld_shift[15:0]};
            default: ;
        endcase
    end

`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
    logic in_misal;
    assign in_misal = ((memop_type_i == MT_HALF) & alu_res_i[0]) |
                      ((memop_type_i != MT_BYTE) & (memop_type_i != MT_HALF) & (alu_res_i[1:0] != 2'b00));
`else
    assign misaligned_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state        <= S_IDLE;
            cap_off      <= '0;
            cap_type     <= '0;
            cap_sext     <= 1'b0;
            cap_store    <= 1'b0;
            cap_we       <= 1'b0;
            cap_waddr    <= '0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            wb_valid_o   <= 1'b0;
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            rf_data_o    <= '0;
            tkbr_o       <= 1'b0;
            new_pc_o     <= '0;
`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
            misaligned_o <= 1'b0;
`endif
        end else begin
            wb_valid_o <= 1'b0;
            rf_we_o    <= 1'b0;
            tkbr_o     <= 1'b0;
`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
            misaligned_o <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (!in_is_mem) begin
                            wb_valid_o <= 1'b1;
                            rf_we_o    <= rf_we_i;
                            rf_waddr_o <= rf_waddr_i;
                            rf_data_o  <= alu_res_i;
                            tkbr_o     <= tkbr_i;
                            new_pc_o   <= new_pc_i;
                        end
`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
                        else if (in_misal) begin
                            wb_valid_o   <= 1'b1;
                            misaligned_o <= 1'b1;
                            rf_waddr_o   <= rf_waddr_i;
                        end
`endif
                        else begin
                            // A set store flag wins over a set load flag.
                            state        <= S_REQ;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= memop_wr_i;
                            dmem_addr_o  <= {alu_res_i[WORD_SIZE-1:2], 2'b00};
                            dmem_be_o    <= in_be;
                            dmem_wdata_o <= in_wdata;
                            cap_off      <= in_off;
                            cap_type     <= memop_type_i;
                            cap_sext     <= memop_sign_ext_i;
                            cap_store    <= memop_wr_i;
                            cap_we       <= rf_we_i;
                            cap_waddr    <= rf_waddr_i;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ack_i) begin
                        state      <= S_IDLE;
                        dmem_req_o <= 1'b0;
                        wb_valid_o <= 1'b1;
                        rf_we_o    <= cap_we & ~cap_store;
                        rf_waddr_o <= cap_waddr;
                        rf_data_o  <= ld_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segre_mem_stage.sv
// Randomized scoreboard bench for segre_mem_stage: a driver pushes expected memory requests and
// write-backs from a behavioural model; a memory responder and a WB monitor pop and compare.
module tb_segre_mem_stage;

    logic        clk_i = 1'b0;
    logic        rsn_i;
    logic        valid_i;
    logic [31:0] alu_res_i;
    logic        rf_we_i;
    logic [4:0]  rf_waddr_i;
    logic [31:0] rf_st_data_i;
    logic [1:0]  memop_type_i;
    logic        memop_rd_i;
    logic        memop_wr_i;
    logic        memop_sign_ext_i;
    logic        tkbr_i;
    logic [31:0] new_pc_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_data_o;
    logic        tkbr_o;
    logic [31:0] new_pc_o;
    logic        misaligned_o;

    segre_mem_stage #(.WORD_SIZE(32), .REG_SIZE(5)) dut (
        .clk_i(clk_i), .rsn_i(rsn_i), .valid_i(valid_i), .alu_res_i(alu_res_i),
        .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_st_data_i(rf_st_data_i),
        .memop_type_i(memop_type_i), .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i),
        .memop_sign_ext_i(memop_sign_ext_i), .tkbr_i(tkbr_i), .new_pc_i(new_pc_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_data_o(rf_data_o),
        .tkbr_o(tkbr_o), .new_pc_o(new_pc_o), .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        tkbr;
        logic [31:0] pc;
        logic        mis;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
    } req_t;

    wb_t  wbq[$];
    req_t rq[$];
    int   total = 0;
    int   bad   = 0;
    bit   resp_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Reference model: the rules of the stage in plain arithmetic.
    task automatic issue(input logic [31:0] alu, input logic we, input logic [4:0] wa,
                         input logic [31:0] sd, input logic [1:0] ty, input logic rd,
                         input logic wr, input logic sx, input logic tk,
                         input logic [31:0] pc, input logic [31:0] rdata, input int dly,
                         input bit expect_it);
        wb_t         e;
        req_t        r;
        bit          mem;
        bit          mis;
        int          off;
        logic [31:0] v;
        int          n;
        mem = rd | wr;
        off = (ty == 2'd0) ? int'(alu % 4) : (ty == 2'd1) ? int'(alu % 4) & 2 : 0;
        mis = 1'b0;
`ifdef SEGRE_MEM_MISALIGN_TRAP_EN
        mis = mem && ((ty == 2'd1 && (alu % 2) != 0) || (ty == 2'd2 && (alu % 4) != 0));
`endif
        if (!mem) begin
            e = '{we: we, waddr: wa, data: alu, tkbr: tk, pc: pc, mis: 1'b0};
        end else if (mis) begin
            e = '{we: 1'b0, waddr: wa, data: 32'h0, tkbr: 1'b0, pc: 32'h0, mis: 1'b1};
        end else begin
            r.we    = wr;
            r.addr  = alu - (alu % 4);
            r.be    = (ty == 2'd0) ? 4'(1 << off) : (ty == 2'd1) ? 4'(3 << off) : 4'hF;
            r.wdata = (ty == 2'd0) ? {24'h0, sd[7:0]} * 32'h01010101 :
                      (ty == 2'd1) ? {16'h0, sd[15:0]} * 32'h00010001 : sd;
            r.rdata = rdata;
            r.dly   = dly;
            v = rdata >> (8 * off);
            if (ty == 2'd0) begin
                v = v & 32'hFF;
                if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (ty == 2'd1) begin
                v = v & 32'hFFFF;
                if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            e = '{we: wr ? 1'b0 : we, waddr: wa, data: v, tkbr: 1'b0, pc: 32'h0, mis: 1'b0};
            if (expect_it) rq.push_back(r);
        end
        if (expect_it) wbq.push_back(e);

        @(posedge clk_i); #1;
        valid_i = 1'b1; alu_res_i = alu; rf_we_i = we; rf_waddr_i = wa; rf_st_data_i = sd;
        memop_type_i = ty; memop_rd_i = rd; memop_wr_i = wr; memop_sign_ext_i = sx;
        tkbr_i = tk; new_pc_i = pc;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        if (expect_it) begin
            if (!mem || mis) chk("wb_latency_1", 32'(wb_valid_o), 32'd1);
            else begin
                chk("memop_no_early_wb", 32'(wb_valid_o), 32'd0);
                chk("memop_req_issued", 32'(dmem_req_o), 32'd1);
            end
        end
        n = 0;
        while ((wbq.size() != 0 || rq.size() != 0) && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 60) fail_now("retire_timeout");
    endtask

    // Memory responder: checks each request against the model, then acks after the chosen delay.
    initial begin
        req_t r;
        forever begin
            @(negedge clk_i);
            if (resp_en && !rsn_i && dmem_req_o) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_dmem_req");
                end else begin
                    r = rq.pop_front();
                    chk("dmem_we", 32'(dmem_we_o), 32'(r.we));
                    chk("dmem_addr", dmem_addr_o, r.addr);
                    chk("dmem_be", 32'(dmem_be_o), 32'(r.be));
                    if (r.we) chk("dmem_wdata", dmem_wdata_o, r.wdata);
                    repeat (r.dly) begin
                        chk("stall_while_waiting", 32'(stall_o), 32'd1);
                        @(negedge clk_i);
                        chk("req_held", 32'(dmem_req_o), 32'd1);
                    end
                    dmem_ack_i = 1'b1;
                    dmem_rdata_i = r.rdata;
                    #1;
                    chk("stall_released_on_ack", 32'(stall_o), 32'd0);
                    @(posedge clk_i); #1;
                    dmem_ack_i = 1'b0;
                    dmem_rdata_i = $urandom;
                end
            end
        end
    end

    // Write-back monitor.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk_i);
            if (!rsn_i && wb_valid_o) begin
                if (wbq.size() == 0) begin
                    fail_now("unexpected_wb_valid");
                end else begin
                    e = wbq.pop_front();
                    chk("wb_rf_we", 32'(rf_we_o), 32'(e.we));
                    chk("wb_waddr", 32'(rf_waddr_o), 32'(e.waddr));
                    chk("wb_tkbr", 32'(tkbr_o), 32'(e.tkbr));
                    chk("wb_misaligned", 32'(misaligned_o), 32'(e.mis));
                    if (e.we) chk("wb_data", rf_data_o, e.data);
                    if (e.tkbr) chk("wb_new_pc", new_pc_o, e.pc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        rsn_i = 1'b1; valid_i = 1'b0; alu_res_i = '0; rf_we_i = 1'b0; rf_waddr_i = '0;
        rf_st_data_i = '0; memop_type_i = '0; memop_rd_i = 1'b0; memop_wr_i = 1'b0;
        memop_sign_ext_i = 1'b0; tkbr_i = 1'b0; new_pc_i = '0; dmem_ack_i = 1'b0;
        dmem_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rsn_i = 1'b0;
        @(negedge clk_i);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr_o), 32'd0);
        chk("rst_rf_data", rf_data_o, 32'd0);
        chk("rst_tkbr", 32'(tkbr_o), 32'd0);
        chk("rst_new_pc", new_pc_o, 32'd0);
        chk("rst_dmem_req", 32'(dmem_req_o), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we_o), 32'd0);
        chk("rst_dmem_addr", dmem_addr_o, 32'd0);
        chk("rst_dmem_be", 32'(dmem_be_o), 32'd0);
        chk("rst_dmem_wdata", dmem_wdata_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_misaligned", 32'(misaligned_o), 32'd0);

        // Directed cases: ALU op, LB sign-ext with delay, SH, LHU, LW at odd address, store-wins.
        issue(32'h1234, 1'b1, 5'd5, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        issue(32'h103, 1'b1, 5'd7, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h80FFFFFF, 2, 1'b1);
        issue(32'h202, 1'b0, 5'd0, 32'hDEADBEEF, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        issue(32'h2, 1'b1, 5'd9, 32'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hABCD0000, 1, 1'b1);
        issue(32'h101, 1'b1, 5'd3, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 0, 1'b1);
        issue(32'h40, 1'b1, 5'd4, 32'h11223344, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b1);

        // Reset while a request is outstanding, then a late ack that must be ignored.
        resp_en = 1'b0;
        issue(32'h300, 1'b1, 5'd6, 32'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        n = 0;
        while (!dmem_req_o && n < 10) begin @(negedge clk_i); n++; end
        chk("req_before_reset", 32'(dmem_req_o), 32'd1);
        #2 rsn_i = 1'b1;
        #1;
        chk("reset_drops_req", 32'(dmem_req_o), 32'd0);
        chk("reset_drops_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1 rsn_i = 1'b0;
        dmem_ack_i = 1'b1;
        @(posedge clk_i); #1 dmem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_no_wb", 32'(wb_valid_o), 32'd0);
        chk("late_ack_no_req", 32'(dmem_req_o), 32'd0);
        resp_en = 1'b1;

        // Taken branch, preceded by a spurious ack while idle.
        @(negedge clk_i); dmem_ack_i = 1'b1;
        @(negedge clk_i); dmem_ack_i = 1'b0;
        chk("idle_ack_no_wb", 32'(wb_valid_o), 32'd0);
        issue(32'h0, 1'b0, 5'd0, 32'h0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom_range(0, 3));
            issue($urandom, 1'($urandom), 5'($urandom), $urandom, 2'($urandom_range(0, 2)),
                  kind == 2'd1 || kind == 2'd3, kind == 2'd2 || kind == 2'd3, 1'($urandom),
                  (kind == 2'd0) ? 1'($urandom) : 1'b0, $urandom, $urandom,
                  $urandom_range(0, 3), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end

        repeat (4) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
